// File: rtl/cmd_dispatch.sv
// Command sequencer: pops NOP/WRITE/READ words from the command FIFO, runs one
// register-bus transaction with timeout, and pushes status (+ read data) to the response FIFO.
module cmd_dispatch #(
  parameter int P_TIMEOUT_CYCLES = 1000,
  parameter int P_ERR_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            cmd_fifo_dout,
  input  logic                   cmd_fifo_empty,
  output logic                   cmd_fifo_rd_en,
  output logic [31:0]            rsp_fifo_din,
  output logic                   rsp_fifo_wr_en,
  input  logic                   rsp_fifo_full,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [15:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  input  logic [31:0]            bus_rdata,
  input  logic                   bus_ack,
  output logic                   busy,
  output logic [P_ERR_CNT_W-1:0] err_cnt
);

  // state   | meaning
  // IDLE    | waiting for a command word
  // HDR     | header word on dout, decode opcode
  // DWAIT   | WRITE: waiting for the data word
  // DLAT    | WRITE: data word on dout
  // BUS     | bus transaction (first cycle raises bus_req)
  // RSP_H   | push response header
  // RSP_D   | push read data
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DWAIT, S_DLAT, S_BUS, S_RSP_H, S_RSP_D
  } state_t;

  localparam int         TW         = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_WRITE   = 4'd1;
  localparam logic [3:0] OP_READ    = 4'd2;
  localparam logic [3:0] ST_OK      = 4'd0;
  localparam logic [3:0] ST_TIMEOUT = 4'd1;
  localparam logic [3:0] ST_BADOP   = 4'd2;

  state_t                 state_q, state_d;
  logic [3:0]             op_q, status_q;
  logic [15:0]            addr_q;
  logic [31:0]            wdata_q, rdata_q;
  logic [7:0]             seq_q;
  logic [TW-1:0]          tcnt_q;
  logic                   bus_req_q;
  logic [P_ERR_CNT_W-1:0] err_q;

  logic [3:0] hdr_op;
  logic       hdr_bad, bus_done, bus_tmo, seq_inc, err_inc;

  assign hdr_op  = cmd_fifo_dout[31:28];
  assign hdr_bad = (hdr_op != OP_NOP) && (hdr_op != OP_WRITE) && (hdr_op != OP_READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cmd_fifo_rd_en = 1'b0;
    rsp_fifo_wr_en = 1'b0;
    rsp_fifo_din   = '0;
    bus_done       = 1'b0;
    bus_tmo        = 1'b0;
    seq_inc        = 1'b0;
    err_inc        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_fifo_empty) begin
          cmd_fifo_rd_en = 1'b1;
          state_d        = S_HDR;
        end
      end
      S_HDR: begin
        if (hdr_op == OP_WRITE)     state_d = S_DWAIT;
        else if (hdr_op == OP_READ) state_d = S_BUS;
        else                        state_d = S_RSP_H;
        err_inc = hdr_bad;
      end
      S_DWAIT: begin
        if (!cmd_fifo_empty) begin
          cmd_fifo_rd_en = 1'b1;
          state_d        = S_DLAT;
        end
      end
      S_DLAT: state_d = S_BUS;
      S_BUS: begin
        // ack wins over a coincident timeout
        if (bus_req_q && bus_ack) begin
          bus_done = 1'b1;
          state_d  = S_RSP_H;
        end else if (bus_req_q && tcnt_q == TW'(P_TIMEOUT_CYCLES)) begin
          bus_tmo = 1'b1;
          err_inc = 1'b1;
          state_d = S_RSP_H;
        end
      end
      S_RSP_H: begin
        rsp_fifo_din = {op_q, status_q, seq_q, addr_q};
        if (!rsp_fifo_full) begin
          rsp_fifo_wr_en = 1'b1;
          if (op_q == OP_READ && status_q == ST_OK) begin
            state_d = S_RSP_D;
          end else begin
            seq_inc = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_RSP_D: begin
        rsp_fifo_din = rdata_q;
        if (!rsp_fifo_full) begin
          rsp_fifo_wr_en = 1'b1;
          seq_inc        = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      status_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      seq_q     <= '0;
      tcnt_q    <= '0;
      bus_req_q <= 1'b0;
      err_q     <= '0;
    end else begin
      if (state_q == S_HDR) begin
        op_q     <= hdr_op;
        addr_q   <= cmd_fifo_dout[15:0];
        status_q <= hdr_bad ? ST_BADOP : ST_OK;
      end
      if (state_q == S_DLAT) wdata_q <= cmd_fifo_dout;
      if (state_q == S_BUS) begin
        if (!bus_req_q) begin
          bus_req_q <= 1'b1;
          tcnt_q    <= TW'(1);
        end else if (bus_done) begin
          bus_req_q <= 1'b0;
          rdata_q   <= bus_rdata;
        end else if (bus_tmo) begin
          bus_req_q <= 1'b0;
          status_q  <= ST_TIMEOUT;
        end else begin
          tcnt_q <= tcnt_q + TW'(1);
        end
      end
      if (seq_inc) seq_q <= seq_q + 8'd1;
      if (err_inc && err_q != '1) err_q <= err_q + P_ERR_CNT_W'(1);
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = (op_q == OP_WRITE);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign err_cnt   = err_q;

endmodule
